// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, state encodings and baud helper for the UART.
// UART_PARITY_EN adds the parity states used by 8E1 framing.
package uart_pkg;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int CNT_W = 16;
  localparam int BIT_W = 3;
`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_WAIT_CTS, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_DISARMED, RX_HUNT, RX_START_CHK, RX_DATA, RX_PARITY_CHK, RX_STOP_CHK} rx_state_e;
`else
  typedef enum logic [2:0] {TX_IDLE, TX_WAIT_CTS, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_DISARMED, RX_HUNT, RX_START_CHK, RX_DATA, RX_STOP_CHK} rx_state_e;
`endif
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: reloadable bit-period down-counter; tick marks the last cycle of a period.
module uart_baud_cnt import uart_pkg::*; #(
  parameter int CPB = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic half_load,
  output logic tick
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CPB / 2 - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign tick = (cnt_q == '0);
  always_comb cnt_d = load ? FULL : half_load ? HALF : tick ? FULL : cnt_q - CNT_W'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= FULL;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_8n1.sv
// uart_8n1: triggered full-duplex 8N1 UART with CTS gating and a shared DONE strobe.
// Define UART_PARITY_EN for 8E1 framing (even parity bit before stop).
module uart_8n1 import uart_pkg::*; #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       RX,
  output logic       TX,
  input  logic       FLOW,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  input  logic       TRG_WRITE,
  input  logic       TRG_READ,
  output logic       DONE
);
  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  tx_state_e tx_state_q, tx_state_d;
  rx_state_e rx_state_q, rx_state_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, dout_q, dout_d;
  logic [BIT_W-1:0] tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
  logic tx_q, tx_d, done_q, wr_prev_q, rd_prev_q, rx_s1_q, rx_s2_q, rx_prev_q;
  logic tx_load, tx_tick, tx_done, rx_half, rx_tick, rx_done, wr_edge, rd_edge;
`ifdef UART_PARITY_EN
  logic tx_par_q, tx_par_d;
`endif
  assign wr_edge  = TRG_WRITE & ~wr_prev_q;
  assign rd_edge  = TRG_READ & ~rd_prev_q;
  assign TX       = tx_q;
  assign DATA_OUT = dout_q;
  assign DONE     = done_q;
  uart_baud_cnt #(.CPB(CPB)) u_tx_baud (
    .clk(CLK_50MHZ), .rst_n(RST), .load(tx_load), .half_load(1'b0), .tick(tx_tick)
  );
  uart_baud_cnt #(.CPB(CPB)) u_rx_baud (
    .clk(CLK_50MHZ), .rst_n(RST), .load(1'b0), .half_load(rx_half), .tick(rx_tick)
  );
  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    tx_idx_d   = tx_idx_q;
    tx_load    = 1'b0;
    tx_done    = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: if (wr_edge) begin
        tx_sh_d    = DATA_IN;
`ifdef UART_PARITY_EN
        tx_par_d   = ^DATA_IN;
`endif
        tx_state_d = TX_WAIT_CTS;
      end
      TX_WAIT_CTS: if (FLOW) begin
        tx_load    = 1'b1;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_tick) begin
        tx_idx_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_tick) begin
        tx_sh_d  = tx_sh_q >> 1;
        tx_idx_d = tx_idx_q + BIT_W'(1);
`ifdef UART_PARITY_EN
        if (tx_idx_q == BIT_W'(7)) tx_state_d = TX_PARITY;
`else
        if (tx_idx_q == BIT_W'(7)) tx_state_d = TX_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_tick) tx_state_d = TX_STOP;
`endif
      TX_STOP: if (tx_tick) begin
        tx_done    = 1'b1;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Line level follows the next state so TX is a clean registered output.
    tx_d = (tx_state_d == TX_START) ? 1'b0 : (tx_state_d == TX_DATA) ? tx_sh_d[0] : IDLE_LEVEL;
`ifdef UART_PARITY_EN
    if (tx_state_d == TX_PARITY) tx_d = tx_par_q;
`endif
  end
  always_comb begin
    rx_state_d = rx_state_q;
    rx_sh_d    = rx_sh_q;
    rx_idx_d   = rx_idx_q;
    dout_d     = dout_q;
    rx_half    = 1'b0;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_DISARMED: if (rd_edge) rx_state_d = RX_HUNT;
      RX_HUNT: if (rx_prev_q && !rx_s2_q) begin
        rx_half    = 1'b1;
        rx_state_d = RX_START_CHK;
      end
      RX_START_CHK: if (rx_tick) begin
        rx_idx_d   = '0;
        rx_state_d = rx_s2_q ? RX_HUNT : RX_DATA;
      end
      RX_DATA: if (rx_tick) begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_idx_d = rx_idx_q + BIT_W'(1);
`ifdef UART_PARITY_EN
        if (rx_idx_q == BIT_W'(7)) rx_state_d = RX_PARITY_CHK;
`else
        if (rx_idx_q == BIT_W'(7)) rx_state_d = RX_STOP_CHK;
`endif
      end
`ifdef UART_PARITY_EN
      RX_PARITY_CHK: if (rx_tick) rx_state_d = (rx_s2_q == ^rx_sh_q) ? RX_STOP_CHK : RX_HUNT;
`endif
      RX_STOP_CHK: if (rx_tick) begin
        rx_state_d = rx_s2_q ? RX_DISARMED : RX_HUNT;
        rx_done    = rx_s2_q;
        dout_d     = rx_s2_q ? rx_sh_q : dout_q;
      end
      default: rx_state_d = RX_DISARMED;
    endcase
  end
  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_DISARMED;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      dout_q     <= '0;
      tx_idx_q   <= '0;
      rx_idx_q   <= '0;
      tx_q       <= IDLE_LEVEL;
      done_q     <= 1'b0;
      wr_prev_q  <= 1'b0;
      rd_prev_q  <= 1'b0;
      rx_s1_q    <= IDLE_LEVEL;
      rx_s2_q    <= IDLE_LEVEL;
      rx_prev_q  <= IDLE_LEVEL;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      dout_q     <= dout_d;
      tx_idx_q   <= tx_idx_d;
      rx_idx_q   <= rx_idx_d;
      tx_q       <= tx_d;
      done_q     <= tx_done | rx_done;
      wr_prev_q  <= TRG_WRITE;
      rd_prev_q  <= TRG_READ;
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end
`ifdef UART_PARITY_EN
  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) tx_par_q <= 1'b0;
    else tx_par_q <= tx_par_d;
  end
`endif
endmodule

// File: tb/tb_uart_8n1.sv
// tb_uart_8n1: directed self-checking bench for the default 8N1 build of uart_8n1.
module tb_uart_8n1;
  localparam int CPB = 434;
  logic CLK_50MHZ = 1'b0, RST = 1'b0, RX = 1'b1, FLOW = 1'b0, TRG_WRITE = 1'b0, TRG_READ = 1'b0;
  logic [7:0] DATA_IN = 8'h00;
  logic [7:0] DATA_OUT;
  logic TX, DONE;
  int checks = 0, errors = 0, done_cnt = 0, done_long = 0;
  logic done_prev = 1'b0;

  uart_8n1 dut (
    .CLK_50MHZ(CLK_50MHZ), .RST(RST), .RX(RX), .TX(TX), .FLOW(FLOW),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .TRG_WRITE(TRG_WRITE),
    .TRG_READ(TRG_READ), .DONE(DONE)
  );

  always #10 CLK_50MHZ = ~CLK_50MHZ;

  always @(posedge CLK_50MHZ) begin
    if (DONE === 1'b1) done_cnt++;
    if (DONE === 1'b1 && done_prev === 1'b1) done_long++;
    done_prev = DONE;
  end

  initial begin
    #(95_000 * 20);
    $display("FAIL watchdog: simulation did not end within 95000 cycles");
    $fatal(1, "timeout");
  end

  // Samples the ten bit centres of the next TX frame, then counts cycles from the start edge to DONE.
  task automatic capture_tx(output logic [9:0] bits, output int len, output logic ok);
    int n = 0;
    bits = 'x;
    len = 0;
    ok = 1'b0;
    while (TX !== 1'b0 && n < 20000) begin @(negedge CLK_50MHZ); n++; end
    if (TX !== 1'b0) return;
    for (int i = 0; i < 10; i++) begin
      repeat (i == 0 ? CPB / 2 : CPB) begin @(negedge CLK_50MHZ); len++; end
      bits[i] = TX;
    end
    while (DONE !== 1'b1 && len < 11 * CPB) begin @(negedge CLK_50MHZ); len++; end
    ok = (DONE === 1'b1);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    RX = 1'b0;
    repeat (CPB) @(negedge CLK_50MHZ);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (CPB) @(negedge CLK_50MHZ);
    end
    RX = stop;
    repeat (CPB) @(negedge CLK_50MHZ);
    RX = 1'b1;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    repeat (3) @(negedge CLK_50MHZ);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", TX); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", DONE); end
    checks++; if (DATA_OUT !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", DATA_OUT); end
    RST = 1'b1;
    repeat (2) @(negedge CLK_50MHZ);
  endtask

  task automatic test_write_hold;
    logic [9:0] bits;
    int len, bad, d0;
    logic ok;
    d0 = done_cnt;
    FLOW = 1'b1;
    DATA_IN = 8'h03;
    TRG_WRITE = 1'b1;
    @(negedge CLK_50MHZ);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL wr_latency1: got %b expected 1", TX); end
    @(negedge CLK_50MHZ);
    checks++; if (TX !== 1'b0) begin errors++; $display("FAIL wr_latency2: got %b expected 0", TX); end
    fork
      begin repeat (3) @(negedge CLK_50MHZ); TRG_WRITE = 1'b0; DATA_IN = 8'hFF; end
      capture_tx(bits, len, ok);
    join
    checks++; if (bits !== {1'b1, 8'h03, 1'b0}) begin errors++; $display("FAIL wr03_bits: got %b expected %b", bits, {1'b1, 8'h03, 1'b0}); end
    checks++; if (len !== 10 * CPB) begin errors++; $display("FAIL wr03_len: got %0d expected %0d", len, 10 * CPB); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr03_done: got %b expected 1", ok); end
    @(negedge CLK_50MHZ);
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL wr03_done_width: got %b expected 0", DONE); end
    bad = 0;
    repeat (2 * CPB) begin @(negedge CLK_50MHZ); if (TX !== 1'b1) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wr03_single_frame: got %0d busy cycles expected 0", bad); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL wr03_done_count: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_write_second;
    logic [9:0] bits;
    int len, d0;
    logic ok;
    d0 = done_cnt;
    DATA_IN = 8'h06;
    TRG_WRITE = 1'b1;
    @(negedge CLK_50MHZ);
    TRG_WRITE = 1'b0;
    capture_tx(bits, len, ok);
    checks++; if (bits !== {1'b1, 8'h06, 1'b0}) begin errors++; $display("FAIL wr06_bits: got %b expected %b", bits, {1'b1, 8'h06, 1'b0}); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr06_done: got %b expected 1", ok); end
    repeat (CPB) @(negedge CLK_50MHZ);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL wr06_done_count: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_flow;
    logic [9:0] bits;
    int len, bad, d0;
    logic ok;
    d0 = done_cnt;
    FLOW = 1'b0;
    DATA_IN = 8'h55;
    TRG_WRITE = 1'b1;
    @(negedge CLK_50MHZ);
    TRG_WRITE = 1'b0;
    @(negedge CLK_50MHZ);
    DATA_IN = 8'hAA;
    TRG_WRITE = 1'b1;
    @(negedge CLK_50MHZ);
    TRG_WRITE = 1'b0;
    bad = 0;
    repeat (3 * CPB) begin @(negedge CLK_50MHZ); if (TX !== 1'b1) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL flow_hold: got %0d busy cycles expected 0", bad); end
    FLOW = 1'b1;
    @(negedge CLK_50MHZ);
    checks++; if (TX !== 1'b0) begin errors++; $display("FAIL flow_start: got %b expected 0", TX); end
    FLOW = 1'b0;
    capture_tx(bits, len, ok);
    checks++; if (bits !== {1'b1, 8'h55, 1'b0}) begin errors++; $display("FAIL flow55_bits: got %b expected %b", bits, {1'b1, 8'h55, 1'b0}); end
    checks++; if (len !== 10 * CPB) begin errors++; $display("FAIL flow55_len: got %0d expected %0d", len, 10 * CPB); end
    FLOW = 1'b1;
    bad = 0;
    repeat (2 * CPB) begin @(negedge CLK_50MHZ); if (TX !== 1'b1) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL flow_no_queue: got %0d busy cycles expected 0", bad); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL flow_done_count: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_rx;
    int d0;
    TRG_READ = 1'b1;
    @(negedge CLK_50MHZ);
    TRG_READ = 1'b0;
    d0 = done_cnt;
    send_rx(8'hA5, 1'b1);
    repeat (CPB) @(negedge CLK_50MHZ);
    checks++; if (DATA_OUT !== 8'hA5) begin errors++; $display("FAIL rxA5_data: got %h expected a5", DATA_OUT); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rxA5_done_count: got %0d expected 1", done_cnt - d0); end
    d0 = done_cnt;
    send_rx(8'h3C, 1'b1);
    repeat (CPB) @(negedge CLK_50MHZ);
    checks++; if (DATA_OUT !== 8'hA5) begin errors++; $display("FAIL rx_disarmed_data: got %h expected a5", DATA_OUT); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rx_disarmed_done: got %0d expected 0", done_cnt - d0); end
  endtask

  task automatic test_rx_errors;
    int d0;
    TRG_READ = 1'b1;
    @(negedge CLK_50MHZ);
    TRG_READ = 1'b0;
    d0 = done_cnt;
    RX = 1'b0;
    repeat (100) @(negedge CLK_50MHZ);
    RX = 1'b1;
    repeat (CPB) @(negedge CLK_50MHZ);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rx_glitch_done: got %0d expected 0", done_cnt - d0); end
    send_rx(8'h7E, 1'b0);
    repeat (2 * CPB) @(negedge CLK_50MHZ);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rx_framing_done: got %0d expected 0", done_cnt - d0); end
    checks++; if (DATA_OUT !== 8'hA5) begin errors++; $display("FAIL rx_framing_data: got %h expected a5", DATA_OUT); end
    send_rx(8'h81, 1'b1);
    repeat (CPB) @(negedge CLK_50MHZ);
    checks++; if (DATA_OUT !== 8'h81) begin errors++; $display("FAIL rx81_data: got %h expected 81", DATA_OUT); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rx81_done_count: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] bits;
    int len, bad, d0, n;
    logic ok;
    DATA_IN = 8'h03;
    TRG_WRITE = 1'b1;
    @(negedge CLK_50MHZ);
    TRG_WRITE = 1'b0;
    n = 0;
    while (TX !== 1'b0 && n < 100) begin @(negedge CLK_50MHZ); n++; end
    repeat (5 * CPB + CPB / 2) @(negedge CLK_50MHZ);
    checks++; if (TX !== 1'b0) begin errors++; $display("FAIL rst_bit4_level: got %b expected 0", TX); end
    d0 = done_cnt;
    RST = 1'b0;
    #1;
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL rst_async_tx: got %b expected 1", TX); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rst_async_done: got %b expected 0", DONE); end
    checks++; if (DATA_OUT !== 8'h00) begin errors++; $display("FAIL rst_async_data_out: got %h expected 00", DATA_OUT); end
    repeat (3) @(negedge CLK_50MHZ);
    RST = 1'b1;
    bad = 0;
    repeat (5 * CPB) begin @(negedge CLK_50MHZ); if (TX !== 1'b1) bad++; end
    checks++; if (bad !== 0 || done_cnt - d0 !== 0) begin errors++; $display("FAIL rst_abort: got %0d busy cycles, %0d DONE pulses expected 0, 0", bad, done_cnt - d0); end
    TRG_WRITE = 1'b1;
    @(negedge CLK_50MHZ);
    TRG_WRITE = 1'b0;
    capture_tx(bits, len, ok);
    checks++; if (bits !== {1'b1, 8'h03, 1'b0}) begin errors++; $display("FAIL rst_rewrite_bits: got %b expected %b", bits, {1'b1, 8'h03, 1'b0}); end
    checks++; if (ok !== 1'b1 || len !== 10 * CPB) begin errors++; $display("FAIL rst_rewrite_done: got done=%b len=%0d expected done=1 len=%0d", ok, len, 10 * CPB); end
    repeat (4) @(negedge CLK_50MHZ);
    checks++; if (done_long !== 0) begin errors++; $display("FAIL done_pulse_width: got %0d long pulses expected 0", done_long); end
  endtask

  initial begin
    test_reset();
    test_write_hold();
    test_write_second();
    test_flow();
    test_rx();
    test_rx_errors();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
